// File: rtl/matrix_pkg.sv
// Shared types and defaults for the matrix loader arbiter slice.
package matrix_pkg;

  localparam int DEF_ROW    = 4;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic TGT_A = 1'b0;
  localparam logic TGT_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to the
// requester that did not own the previous load.
module rr_arbiter2 (
  input  logic [1:0] req_valid,
  input  logic       last_owner,
  output logic       any_req,
  output logic       grant
);

  always_comb begin
    any_req = |req_valid;
    case (req_valid)
      2'b00:   grant = 1'b0;
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_owner;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/matrix_load_arbiter.sv
// Grants whole ROW-word matrix loads to the host or DMA requester and steers
// the words to the Matrix A or Matrix B loader; tracks operand freshness.
module matrix_load_arbiter
  import matrix_pkg::*;
#(
  parameter int ROW    = DEF_ROW,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_target,
  input  logic [2*DATA_W-1:0] req_data,
  output logic [1:0]          req_ready,
  output logic                A_opcode,
  output logic [DATA_W-1:0]   Data_to_A,
  output logic                B_opcode,
  output logic [DATA_W-1:0]   Data_to_B,
  output logic                busy,
  output logic                load_done,
  output logic                done_target,
  output logic                done_owner,
  output logic                mats_ready,
  input  logic                consume
);

  localparam int               CNT_W    = (ROW > 1) ? $clog2(ROW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROW - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                owner_q, owner_d;
  logic                target_q, target_d;
  logic                last_owner_q, last_owner_d;
  logic                loaded_a_q, loaded_a_d;
  logic                loaded_b_q, loaded_b_d;
  logic                a_op_q, a_op_d;
  logic                b_op_q, b_op_d;
  logic [DATA_W-1:0]   a_data_q, a_data_d;
  logic [DATA_W-1:0]   b_data_q, b_data_d;

  logic                any_req;
  logic                grant_owner;
  logic                hs;
  logic                last_hs;
  logic [DATA_W-1:0]   owner_word;

  rr_arbiter2 u_arb (
    .req_valid  (req_valid),
    .last_owner (last_owner_q),
    .any_req    (any_req),
    .grant      (grant_owner)
  );

  // Ready is only ever raised for the owner in BURST, so its valid alone marks a handshake.
  assign owner_word = owner_q ? req_data[2*DATA_W-1 -: DATA_W] : req_data[DATA_W-1:0];
  assign hs         = (state_q == BURST) && req_valid[owner_q];
  assign last_hs    = hs && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = BURST; else state_d = IDLE;
      BURST:   if (last_hs) state_d = DONE;  else state_d = BURST;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 2'b00;
    busy        = 1'b0;
    load_done   = 1'b0;
    done_target = 1'b0;
    done_owner  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 2'b00;
      end
      BURST: begin
        busy      = 1'b1;
        req_ready = owner_q ? 2'b10 : 2'b01;
      end
      DONE: begin
        busy        = 1'b1;
        load_done   = 1'b1;
        done_target = target_q;
        done_owner  = owner_q;
      end
      default: begin
        req_ready = 2'b00;
      end
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    target_d     = target_q;
    last_owner_d = last_owner_q;
    a_op_d       = 1'b0;
    b_op_d       = 1'b0;
    a_data_d     = a_data_q;
    b_data_d     = b_data_q;
    loaded_a_d   = consume ? 1'b0 : loaded_a_q;
    loaded_b_d   = consume ? 1'b0 : loaded_b_q;

    if ((state_q == IDLE) && any_req) begin
      owner_d  = grant_owner;
      target_d = req_target[grant_owner];
    end else begin
      owner_d  = owner_q;
    end

    if (hs) begin
      cnt_d = last_hs ? '0 : cnt_q + 1'b1;
      if (target_q == TGT_B) begin
        b_op_d   = 1'b1;
        b_data_d = owner_word;
      end else begin
        a_op_d   = 1'b1;
        a_data_d = owner_word;
      end
    end else begin
      cnt_d = cnt_q;
    end

    // A load finishing in the same cycle as consume still marks its target fresh.
    if (state_q == DONE) begin
      last_owner_d = owner_q;
      if (target_q == TGT_A) begin
        loaded_a_d = 1'b1;
      end else begin
        loaded_b_d = 1'b1;
      end
    end else begin
      last_owner_d = last_owner_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      target_q     <= 1'b0;
      last_owner_q <= 1'b1;
      loaded_a_q   <= 1'b0;
      loaded_b_q   <= 1'b0;
      a_op_q       <= 1'b0;
      b_op_q       <= 1'b0;
      a_data_q     <= '0;
      b_data_q     <= '0;
    end else begin
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      target_q     <= target_d;
      last_owner_q <= last_owner_d;
      loaded_a_q   <= loaded_a_d;
      loaded_b_q   <= loaded_b_d;
      a_op_q       <= a_op_d;
      b_op_q       <= b_op_d;
      a_data_q     <= a_data_d;
      b_data_q     <= b_data_d;
    end
  end

  assign A_opcode   = a_op_q;
  assign Data_to_A  = a_data_q;
  assign B_opcode   = b_op_q;
  assign Data_to_B  = b_data_q;
  assign mats_ready = loaded_a_q & loaded_b_q;

endmodule
